spi_master_tx: RTL and testbench

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_master_tx.sv | 164 ++++++++++++++++
 tb/tb_spi_master_tx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit-only master. Sends one 32-bit word MSB first per
// transaction. The word frame is SETUP, then 32 HIGH/LOW pairs, then GAP,
// and every phase lasts CLK_DIV clk cycles. Every output comes straight
// from a flop. Each flop is loaded from the next-state decode, so the
// outputs always match the state that is being entered.
module spi_master_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_valid,
   input  logic [31:0] tx_data,
   output logic        tx_ready,
   output logic        busy,
   output logic        done,
   output logic        SCK,
   output logic        SSEL,
   output logic        MOSI
);

   generate
      if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
         $error("spi_master_tx: CLK_DIV must be within 4..255");
      end
   endgenerate

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_GAP
   } state_t;

   state_t      r_state;
   logic [7:0]  r_div;
   logic [4:0]  r_bit;
   logic [31:0] r_shift;
   logic        r_tx_ready;
   logic        r_busy;
   logic        r_done;
   logic        r_sck;
   logic        r_ssel;
   logic        r_mosi;

   state_t      w_state_next;
   logic [7:0]  w_div_next;
   logic [4:0]  w_bit_next;
   logic [31:0] w_shift_next;
   logic        w_tx_ready_next;
   logic        w_busy_next;
   logic        w_done_next;
   logic        w_sck_next;
   logic        w_ssel_next;
   logic        w_mosi_next;
   logic        w_phase_end;

   assign w_phase_end = (r_div == DIV_LAST);

   // Compute the next state, the counters and the registered output values.
   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;

      // Every state except IDLE times out after CLK_DIV cycles.
      if (r_state != S_IDLE) begin
         w_div_next = w_phase_end ? 8'd0 : r_div + 8'd1;
      end

      case (r_state)
         S_IDLE: begin
            w_div_next = 8'd0;
            // A word is accepted only when tx_ready is visible.
            // After reset, this keeps the first IDLE cycle closed.
            if (tx_valid && r_tx_ready) begin
               w_state_next = S_SETUP;
               w_shift_next = tx_data;
               w_bit_next   = 5'd31;
            end
         end
         S_SETUP: begin
            if (w_phase_end) begin
               w_state_next = S_HIGH;
            end
         end
         S_HIGH: begin
            if (w_phase_end) begin
               w_state_next = S_LOW;
               // Present the next bit as SCK falls. After bit 0, hold it
               // so that the final LOW phase acts as SSEL hold time.
               if (r_bit != 5'd0) begin
                  w_shift_next = {r_shift[30:0], 1'b0};
               end
            end
         end
         S_LOW: begin
            if (w_phase_end) begin
               if (r_bit == 5'd0) begin
                  w_state_next = S_GAP;
               end else begin
                  w_state_next = S_HIGH;
                  w_bit_next   = r_bit - 5'd1;
               end
            end
         end
         S_GAP: begin
            if (w_phase_end) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_div_next   = 8'd0;
         end
      endcase

      w_tx_ready_next = (w_state_next == S_IDLE);
      w_busy_next     = (w_state_next != S_IDLE);
      w_done_next     = (w_state_next == S_GAP) && (r_state != S_GAP);
      w_sck_next      = (w_state_next == S_HIGH);
      w_ssel_next     = !((w_state_next == S_SETUP) || (w_state_next == S_HIGH) ||
                          (w_state_next == S_LOW));
      w_mosi_next     = w_ssel_next ? 1'b0 : w_shift_next[31];
   end

   // State, counters and outputs. Reset forces an idle, deselected bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_div      <= 8'd0;
         r_bit      <= 5'd0;
         r_shift    <= 32'd0;
         r_tx_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sck      <= 1'b0;
         r_ssel     <= 1'b1;
         r_mosi     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_div      <= w_div_next;
         r_bit      <= w_bit_next;
         r_shift    <= w_shift_next;
         r_tx_ready <= w_tx_ready_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_sck      <= w_sck_next;
         r_ssel     <= w_ssel_next;
         r_mosi     <= w_mosi_next;
      end
   end

   assign tx_ready = r_tx_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign SCK      = r_sck;
   assign SSEL     = r_ssel;
   assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx. It instantiates the design twice, with CLK_DIV=4
// and CLK_DIV=7. A behavioural SPI slave watches each bus on the falling
// clk edge. The slave shifts MOSI in on every SCK rise while SSEL is low.
// When SSEL rises, it logs the word, the count of SCK rises and the SSEL-low
// length. It also counts phase-length, MOSI-timing and idle-bus violations.
`timescale 1ns/1ps
module tb_spi_master_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  valid = 2'b00;
   logic [31:0] data [2];
   logic [1:0]  ready, busy, done, sck, ssel, mosi;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_master_tx #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data[0]),
      .tx_ready(ready[0]), .busy(busy[0]), .done(done[0]),
      .SCK(sck[0]), .SSEL(ssel[0]), .MOSI(mosi[0])
   );

   spi_master_tx #(.CLK_DIV(7)) u_dut7 (
      .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data[1]),
      .tx_ready(ready[1]), .busy(busy[1]), .done(done[1]),
      .SCK(sck[1]), .SSEL(ssel[1]), .MOSI(mosi[1])
   );

   function automatic int div_of(input int m);
      return (m == 0) ? 4 : 7;
   endfunction

   // Slave-side monitor state
   int          cyc = 0;
   logic [31:0] cur_word [2];
   int          cur_rises [2], cur_low [2], run_len [2];
   int          phase_err [2], mosi_err [2], idle_err [2], done_err [2], done_cnt [2];
   int          n_words [2], n_acc [2];
   logic [31:0] word_log [2][128];
   int          rise_log [2][128], low_log [2][128];
   logic [31:0] acc_data [2][128];
   int          acc_cyc [2][128];
   logic [1:0]  prev_ssel, prev_sck, prev_mosi;

   // Behavioural slave and bus-timing observer, sampled on falling clk.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            cur_word[m]  <= 32'd0;
            cur_rises[m] <= 0;
            cur_low[m]   <= 0;
            run_len[m]   <= 0;
            prev_ssel[m] <= 1'b1;
            prev_sck[m]  <= 1'b0;
            prev_mosi[m] <= 1'b0;
         end else begin
            prev_ssel[m] <= ssel[m];
            prev_sck[m]  <= sck[m];
            prev_mosi[m] <= mosi[m];
            if (!ssel[m]) begin
               cur_low[m] <= cur_low[m] + 1;
               if (sck[m] && !prev_sck[m]) begin
                  cur_word[m]  <= {cur_word[m][30:0], mosi[m]};
                  cur_rises[m] <= cur_rises[m] + 1;
               end
               if (prev_ssel[m]) begin
                  run_len[m] <= 1;
               end else if (sck[m] != prev_sck[m]) begin
                  if (run_len[m] != div_of(m)) phase_err[m] <= phase_err[m] + 1;
                  run_len[m] <= 1;
               end else begin
                  run_len[m] <= run_len[m] + 1;
               end
               if (!prev_ssel[m] && (mosi[m] !== prev_mosi[m]) && !(prev_sck[m] && !sck[m]))
                  mosi_err[m] <= mosi_err[m] + 1;
            end else begin
               if (sck[m] || mosi[m]) idle_err[m] <= idle_err[m] + 1;
               if (!prev_ssel[m]) begin
                  if (run_len[m] != div_of(m)) phase_err[m] <= phase_err[m] + 1;
                  word_log[m][n_words[m] & 127] <= cur_word[m];
                  rise_log[m][n_words[m] & 127] <= cur_rises[m];
                  low_log[m][n_words[m] & 127]  <= cur_low[m];
                  n_words[m]   <= n_words[m] + 1;
                  cur_word[m]  <= 32'd0;
                  cur_rises[m] <= 0;
                  cur_low[m]   <= 0;
               end
            end
         end
         if (done[m] === 1'b1) begin
            done_cnt[m] <= done_cnt[m] + 1;
            if (reset || !(ssel[m] && !prev_ssel[m])) done_err[m] <= done_err[m] + 1;
         end
         if (valid[m] && ready[m] && !reset) begin
            acc_data[m][n_acc[m] & 127] <= data[m];
            acc_cyc[m][n_acc[m] & 127]  <= cyc;
            n_acc[m] <= n_acc[m] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for tx_ready, then present one word for a single cycle.
   task automatic offer(input int m, input logic [31:0] w, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (ready[m] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         valid[m] = 1'b1;
         data[m]  = w;
         tick();
         valid[m] = 1'b0;
      end
   endtask

   // Wait until the slave has logged more than 'start' words.
   task automatic wait_word(input int m, input int start, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80 * div_of(m) + 40; i++) begin
         if (n_words[m] > start) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid = 2'b00;
      data[0] = 32'd0;
      data[1] = 32'd0;
      repeat (3) tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if ({ssel[m], sck[m], mosi[m], ready[m], busy[m], done[m]} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_state m=%0d got={ssel,sck,mosi,rdy,busy,done}=%b exp=100000", m,
                     {ssel[m], sck[m], mosi[m], ready[m], busy[m], done[m]});
         end
      end
      reset = 1'b0;
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if ({ready[m], busy[m], ssel[m]} !== 3'b101) begin
            errors++;
            $display("FAIL ready_after_reset m=%0d got={rdy,busy,ssel}=%b exp=101", m,
                     {ready[m], busy[m], ssel[m]});
         end
      end
      $display("reset test complete");
   endtask

   task automatic test_basic();
      bit   ok;
      int   start = n_words[0];
      int   dstart = done_cnt[0];
      logic [31:0] w = 32'hA5A5F00F;
      offer(0, w, ok);
      checks++;
      if ({ok, busy[0], ready[0], ssel[0], sck[0], mosi[0]} !== 6'b110001) begin
         errors++;
         $display("FAIL setup_start got={ok,busy,rdy,ssel,sck,mosi}=%b exp=110001",
                  {ok, busy[0], ready[0], ssel[0], sck[0], mosi[0]});
      end
      wait_word(0, start, ok);
      tick();
      checks++;
      if (!ok || word_log[0][start & 127] !== w) begin
         errors++;
         $display("FAIL basic_word got=%h exp=%h (ok=%0d)", word_log[0][start & 127], w, ok);
      end
      checks++;
      if (rise_log[0][start & 127] != 32 || low_log[0][start & 127] != 260) begin
         errors++;
         $display("FAIL basic_timing rises=%0d exp=32 ssel_low=%0d exp=260",
                  rise_log[0][start & 127], low_log[0][start & 127]);
      end
      checks++;
      if (done_cnt[0] - dstart != 1 || done_err[0] != 0) begin
         errors++;
         $display("FAIL basic_done pulses=%0d exp=1 misplaced=%0d", done_cnt[0] - dstart, done_err[0]);
      end
      $display("word m=0 sent=%h received=%h", w, word_log[0][start & 127]);
   endtask

   task automatic test_loopback();
      bit ok1, ok2, ok3;
      int start = n_words[0];
      logic [31:0] exp_q [$];
      exp_q.push_back(32'h12345678);
      exp_q.push_back(32'hDEADBEEF);
      offer(0, exp_q[0], ok1);
      offer(0, exp_q[1], ok2);
      wait_word(0, start + 1, ok3);
      tick();
      checks++;
      if (!(ok1 && ok2 && ok3) || n_words[0] - start != 2) begin
         errors++;
         $display("FAIL loopback_count got=%0d exp=2", n_words[0] - start);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (word_log[0][(start + k) & 127] !== exp_q[k]) begin
            errors++;
            $display("FAIL loopback_word%0d got=%h exp=%h", k, word_log[0][(start + k) & 127], exp_q[k]);
         end
         $display("word m=0 sent=%h received=%h", exp_q[k], word_log[0][(start + k) & 127]);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         bit   ok, ok2;
         int   m = k % 2;
         int   start = n_words[m];
         logic [31:0] w = $urandom;
         offer(m, w, ok);
         wait_word(m, start, ok2);
         tick();
         checks++;
         if (!(ok && ok2) || word_log[m][start & 127] !== w ||
             rise_log[m][start & 127] != 32 || low_log[m][start & 127] != 65 * div_of(m)) begin
            errors++;
            $display("FAIL random_word m=%0d got=%h exp=%h rises=%0d low=%0d exp_low=%0d", m,
                     word_log[m][start & 127], w, rise_log[m][start & 127],
                     low_log[m][start & 127], 65 * div_of(m));
         end
         $display("word m=%0d sent=%h received=%h", m, w, word_log[m][start & 127]);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int astart = n_acc[0];
      int wstart = n_words[0];
      valid[0] = 1'b1;
      for (int i = 0; i < 1200 && (n_acc[0] - astart) < 3; i++) begin
         data[0] = $urandom;
         tick();
      end
      valid[0] = 1'b0;
      wait_word(0, wstart + 2, ok);
      tick();
      checks++;
      if (!ok || n_acc[0] - astart != 3) begin
         errors++;
         $display("FAIL b2b_accepts got=%0d exp=3", n_acc[0] - astart);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (word_log[0][(wstart + k) & 127] !== acc_data[0][(astart + k) & 127]) begin
            errors++;
            $display("FAIL b2b_word%0d got=%h exp=%h", k, word_log[0][(wstart + k) & 127],
                     acc_data[0][(astart + k) & 127]);
         end
         $display("word m=0 accepted=%h received=%h", acc_data[0][(astart + k) & 127],
                  word_log[0][(wstart + k) & 127]);
      end
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (acc_cyc[0][(astart + k) & 127] - acc_cyc[0][(astart + k - 1) & 127] != 66 * 4 + 1) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d exp=%0d",
                     acc_cyc[0][(astart + k) & 127] - acc_cyc[0][(astart + k - 1) & 127], 66 * 4 + 1);
         end
      end
   endtask

   task automatic test_abort();
      bit ok, ok2, reached;
      int wstart = n_words[0];
      int dstart;
      int istart;
      offer(0, 32'hFFFFFFFF, ok);
      reached = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (cur_rises[0] == 22) begin
            reached = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!(ok && reached)) begin
         errors++;
         $display("FAIL abort_reach_bit10 got=%0d exp=22", cur_rises[0]);
      end
      dstart = done_cnt[0];
      reset = 1'b1;
      tick();
      checks++;
      if ({ssel[0], sck[0], done[0]} !== 3'b100) begin
         errors++;
         $display("FAIL abort_bus got={ssel,sck,done}=%b exp=100", {ssel[0], sck[0], done[0]});
      end
      reset = 1'b0;
      istart = idle_err[0];
      repeat (300) tick();
      checks++;
      if (done_cnt[0] != dstart || n_words[0] != wstart || idle_err[0] != istart || ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_quiet done=%0d exp=%0d words=%0d exp=%0d idle_err=%0d rdy=%b",
                  done_cnt[0], dstart, n_words[0], wstart, idle_err[0] - istart, ready[0]);
      end
      offer(0, 32'h00000001, ok);
      wait_word(0, wstart, ok2);
      tick();
      checks++;
      if (!(ok && ok2) || word_log[0][wstart & 127] !== 32'h00000001 || rise_log[0][wstart & 127] != 32) begin
         errors++;
         $display("FAIL abort_next_word got=%h exp=00000001 rises=%0d",
                  word_log[0][wstart & 127], rise_log[0][wstart & 127]);
      end
      $display("word m=0 sent=00000001 received=%h after abort", word_log[0][wstart & 127]);
   endtask

   task automatic test_div7();
      bit ok, ok2;
      int start = n_words[1];
      int pstart = phase_err[1];
      int mstart = mosi_err[1];
      offer(1, 32'h80000001, ok);
      wait_word(1, start, ok2);
      tick();
      checks++;
      if (!(ok && ok2) || word_log[1][start & 127] !== 32'h80000001 || low_log[1][start & 127] != 455) begin
         errors++;
         $display("FAIL div7_word got=%h exp=80000001 low=%0d exp=455",
                  word_log[1][start & 127], low_log[1][start & 127]);
      end
      checks++;
      if (phase_err[1] != pstart || mosi_err[1] != mstart) begin
         errors++;
         $display("FAIL div7_phases phase_err=%0d mosi_err=%0d exp=0 0",
                  phase_err[1] - pstart, mosi_err[1] - mstart);
      end
      $display("word m=1 sent=80000001 received=%h", word_log[1][start & 127]);
   endtask

   task automatic test_reset_valid();
      int astart = n_acc[0];
      repeat (5) tick();
      reset = 1'b1;
      valid[0] = 1'b1;
      data[0] = 32'hCAFEF00D;
      tick();
      reset = 1'b0;
      valid[0] = 1'b0;
      tick();
      checks++;
      if ({ready[0], busy[0], ssel[0]} !== 3'b101 || n_acc[0] != astart) begin
         errors++;
         $display("FAIL reset_vs_valid got={rdy,busy,ssel}=%b exp=101 accepts=%0d",
                  {ready[0], busy[0], ssel[0]}, n_acc[0] - astart);
      end
      repeat (10) tick();
      checks++;
      if (ssel[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_vs_valid_idle got ssel=%b busy=%b exp=1 0", ssel[0], busy[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loopback();
      test_random();
      test_back_to_back();
      test_abort();
      test_div7();
      test_reset_valid();
      checks++;
      if (phase_err[0] != 0 || mosi_err[0] != 0 || idle_err[0] != 0 || done_err[0] != 0 ||
          phase_err[1] != 0 || mosi_err[1] != 0 || idle_err[1] != 0 || done_err[1] != 0) begin
         errors++;
         $display("FAIL bus_rules phase=%0d/%0d mosi=%0d/%0d idle=%0d/%0d done=%0d/%0d exp all 0",
                  phase_err[0], phase_err[1], mosi_err[0], mosi_err[1],
                  idle_err[0], idle_err[1], done_err[0], done_err[1]);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
